// File: rtl/scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : scanner_if
// Brief    : Command, serial-link and debug signals of the scanner controller.
// Revision : 1.0 - initial release
// ============================================================================
interface scanner_if;
  logic       readyForTransferIn;
  logic [1:0] localTransferInput;
  logic       clkOut;
  logic       dataOut;
  logic       commandDoneBit;
  logic [1:0] ps;
  logic [3:0] dataBuffer;
  logic [2:0] slowCount;
  logic [2:0] dataBitCounter;

  // Controller side.
  modport master (
    input  readyForTransferIn, localTransferInput,
    output clkOut, dataOut, commandDoneBit,
    output ps, dataBuffer, slowCount, dataBitCounter
  );

  // Command decoder / receiver side.
  modport slave (
    output readyForTransferIn, localTransferInput,
    input  clkOut, dataOut, commandDoneBit,
    input  ps, dataBuffer, slowCount, dataBitCounter
  );
endinterface
`default_nettype wire

// File: rtl/scanner_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scanner_ctrl
// Brief    : Fills a buffer at a divided rate, then drains it as serial words.
//            Option: SCANNER_DONE_HOLD_EN makes commandDoneBit sticky.
// Revision : 1.0 - initial release
// ============================================================================
module scanner_ctrl #(
  parameter int FULL_LEVEL = 15
) (
  input  wire logic  clk,
  input  wire logic  rst,
  scanner_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SCAN  = 2'b01,
    READY = 2'b10,
    XFER  = 2'b11
  } stateT;

  localparam logic [1:0] c_CMD_START = 2'b01;
  localparam logic [1:0] c_CMD_ABORT = 2'b10;
  localparam logic [3:0] c_FULL      = 4'(FULL_LEVEL);
  localparam logic [3:0] c_WORD_TAG  = 4'b1010;

  stateT      r_state, w_nextState;
  logic [2:0] r_slowCount, w_nextSlow;
  logic [3:0] r_dataBuffer, w_nextBuffer;
  logic [2:0] r_bitCounter, w_nextBit;
  logic       r_dataOut, w_nextDataOut;
  logic       r_done, w_nextDone, w_doneEvent;
  logic       w_start, w_abort, w_tick;
  logic [7:0] w_nextWord;

  always_comb begin
    w_nextState  = r_state;
    w_nextSlow   = r_slowCount;
    w_nextBuffer = r_dataBuffer;
    w_nextBit    = r_bitCounter;
    w_doneEvent  = 1'b0;
    w_start      = (bus.localTransferInput == c_CMD_START);
    w_abort      = (bus.localTransferInput == c_CMD_ABORT);
    w_tick       = (r_slowCount == 3'd7);

    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_nextState  = SCAN;
          w_nextBuffer = 4'd0;
        end
      end
      SCAN: begin
        if (w_abort) begin
          w_nextState = IDLE;
        end else begin
          w_nextSlow = r_slowCount + 3'd1;
          if (w_tick) begin
            w_nextBuffer = r_dataBuffer + 4'd1;
            if (w_nextBuffer == c_FULL) w_nextState = READY;
          end
        end
      end
      READY: begin
        if (w_abort) begin
          w_nextState = IDLE;
        end else if (bus.readyForTransferIn) begin
          w_nextState = XFER;
          w_nextBit   = 3'd0;
        end
      end
      XFER: begin
        if (w_abort) begin
          w_nextState = IDLE;
        end else if (bus.readyForTransferIn) begin
          w_nextSlow = r_slowCount + 3'd1;
          if (w_tick) begin
            if (r_bitCounter != 3'd7) begin
              w_nextBit = r_bitCounter + 3'd1;
            end else begin
              w_nextBit    = 3'd0;
              w_nextBuffer = r_dataBuffer - 4'd1;
              if (w_nextBuffer == 4'd0) begin
                w_nextState = IDLE;
                w_doneEvent = 1'b1;
              end
            end
          end
        end
      end
    endcase

    if (w_nextState != r_state) w_nextSlow = 3'd0;
    if (w_nextState == IDLE) begin
      w_nextBuffer = 4'd0;
      w_nextBit    = 3'd0;
    end

    // Serial bit is derived from the next counters so it is valid on XFER entry.
    w_nextWord    = {c_WORD_TAG, w_nextBuffer};
    w_nextDataOut = (w_nextState == XFER) ? w_nextWord[3'd7 - w_nextBit] : 1'b0;

`ifdef SCANNER_DONE_HOLD_EN
    w_nextDone = w_doneEvent | (r_done & ~(w_start | w_abort));
`else
    w_nextDone = w_doneEvent;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_slowCount  <= 3'd0;
      r_dataBuffer <= 4'd0;
      r_bitCounter <= 3'd0;
      r_dataOut    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_slowCount  <= w_nextSlow;
      r_dataBuffer <= w_nextBuffer;
      r_bitCounter <= w_nextBit;
      r_dataOut    <= w_nextDataOut;
      r_done       <= w_nextDone;
    end
  end

  // Link clock idles low whenever the transfer is not actively advancing.
  assign bus.clkOut         = (r_state == XFER) && bus.readyForTransferIn && r_slowCount[2];
  assign bus.dataOut        = r_dataOut;
  assign bus.commandDoneBit = r_done;
  assign bus.ps             = r_state;
  assign bus.dataBuffer     = r_dataBuffer;
  assign bus.slowCount      = r_slowCount;
  assign bus.dataBitCounter = r_bitCounter;

endmodule
`default_nettype wire

// File: tb/tb_scanner_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scanner_ctrl
// Brief    : Self-checking bench for scanner_ctrl with a serial-bit scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scanner_ctrl;

  localparam int c_FULL = 15;
`ifdef SCANNER_DONE_HOLD_EN
  localparam logic c_HOLD = 1'b1;
`else
  localparam logic c_HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scanner_if bus ();

  scanner_ctrl #(.FULL_LEVEL(c_FULL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   nTests = 0;
  int   nFail  = 0;
  logic sbQ[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected serial stream for a complete drain from a full buffer.
  task automatic pushTransfer();
    logic [7:0] w;
    for (int b = c_FULL; b >= 1; b--) begin
      w = {4'b1010, 4'(b)};
      for (int i = 7; i >= 0; i--) sbQ.push_back(w[i]);
    end
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, ".ps"},   32'(bus.ps), 32'd0);
    chk({tag, ".buf"},  32'(bus.dataBuffer), 32'd0);
    chk({tag, ".slow"}, 32'(bus.slowCount), 32'd0);
    chk({tag, ".bit"},  32'(bus.dataBitCounter), 32'd0);
    chk({tag, ".dout"}, 32'(bus.dataOut), 32'd0);
    chk({tag, ".clk"},  32'(bus.clkOut), 32'd0);
    chk({tag, ".done"}, 32'(bus.commandDoneBit), 32'd0);
  endtask

  // Receiver model: sample the line on each link-clock rising edge.
  always @(posedge bus.clkOut) begin
    #1;
    if (sbQ.size() == 0) chk("sbUnderflow", 32'd1, 32'd0);
    else                 chk("serialBit", 32'(bus.dataOut), 32'(sbQ.pop_front()));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.readyForTransferIn = 1'b0;
    bus.localTransferInput = 2'b00;

    // Reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkIdle("reset");
    bus.localTransferInput = 2'b11;
    tick(2);
    bus.localTransferInput = 2'b10;
    tick();
    bus.localTransferInput = 2'b00;
    tick(2);
    checkIdle("idleHold");

    // Scan
    bus.localTransferInput = 2'b01;
    tick();
    bus.localTransferInput = 2'b00;
    chk("scanPs", 32'(bus.ps), 32'd1);
    chk("scanBuf0", 32'(bus.dataBuffer), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("scanSlow", 32'(bus.slowCount), 32'(i));
      tick();
    end
    chk("scanBuf1", 32'(bus.dataBuffer), 32'd1);
    chk("scanSlowWrap", 32'(bus.slowCount), 32'd0);
    tick(111);
    chk("scanNotYetPs", 32'(bus.ps), 32'd1);
    chk("scanNotYetBuf", 32'(bus.dataBuffer), 32'd14);
    tick();
    chk("readyPs", 32'(bus.ps), 32'd2);
    chk("readyBuf", 32'(bus.dataBuffer), 32'd15);
    chk("readySlow", 32'(bus.slowCount), 32'd0);
    bus.localTransferInput = 2'b01;
    tick(2);
    bus.localTransferInput = 2'b00;
    chk("startIgnored", 32'(bus.ps), 32'd2);
    chk("readyClk", 32'(bus.clkOut), 32'd0);

    // Handshake and first word
    bus.readyForTransferIn = 1'b1;
    pushTransfer();
    tick();
    chk("xferPs", 32'(bus.ps), 32'd3);
    chk("xferBit0", 32'(bus.dataBitCounter), 32'd0);
    chk("xferSlow0", 32'(bus.slowCount), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("bit0Clk", 32'(bus.clkOut), (i >= 4) ? 32'd1 : 32'd0);
      chk("bit0Hold", 32'(bus.dataOut), 32'd1);
      tick();
    end
    chk("bit1Idx", 32'(bus.dataBitCounter), 32'd1);
    chk("bit1Val", 32'(bus.dataOut), 32'd0);
    tick(56);
    chk("word2Buf", 32'(bus.dataBuffer), 32'd14);
    chk("word2Bit", 32'(bus.dataBitCounter), 32'd0);

    // Pause mid-word, in the low half of the link clock
    tick(17);
    chk("prePauseBit", 32'(bus.dataBitCounter), 32'd2);
    chk("prePauseSlow", 32'(bus.slowCount), 32'd1);
    bus.readyForTransferIn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("pauseSlow", 32'(bus.slowCount), 32'd1);
      chk("pauseBit", 32'(bus.dataBitCounter), 32'd2);
      chk("pauseBuf", 32'(bus.dataBuffer), 32'd14);
      chk("pauseDout", 32'(bus.dataOut), 32'd1);
      chk("pauseClk", 32'(bus.clkOut), 32'd0);
    end
    bus.readyForTransferIn = 1'b1;

    // Completion
    tick(878);
    chk("lastPs", 32'(bus.ps), 32'd3);
    chk("lastBuf", 32'(bus.dataBuffer), 32'd1);
    chk("lastBit", 32'(bus.dataBitCounter), 32'd7);
    chk("lastDone", 32'(bus.commandDoneBit), 32'd0);
    tick();
    chk("donePs", 32'(bus.ps), 32'd0);
    chk("doneBuf", 32'(bus.dataBuffer), 32'd0);
    chk("doneFlag", 32'(bus.commandDoneBit), 32'd1);
    chk("doneDout", 32'(bus.dataOut), 32'd0);
    chk("sbEmpty", 32'(sbQ.size()), 32'd0);
    tick();
    chk("doneAfter1", 32'(bus.commandDoneBit), 32'(c_HOLD));
    tick(2);
    chk("doneAfter3", 32'(bus.commandDoneBit), 32'(c_HOLD));
    bus.readyForTransferIn = 1'b0;

    // Abort during scan, coincident with a slow tick
    bus.localTransferInput = 2'b01;
    tick();
    bus.localTransferInput = 2'b00;
    chk("doneClrOnStart", 32'(bus.commandDoneBit), 32'd0);
    chk("rescanPs", 32'(bus.ps), 32'd1);
    tick(23);
    chk("abortScanSlow", 32'(bus.slowCount), 32'd7);
    bus.localTransferInput = 2'b10;
    tick();
    bus.localTransferInput = 2'b00;
    checkIdle("abortScan");
    tick();
    chk("abortScanNoDone", 32'(bus.commandDoneBit), 32'd0);

    // Abort during transfer, coincident with a slow tick
    bus.localTransferInput = 2'b01;
    tick();
    bus.localTransferInput = 2'b00;
    tick(120);
    chk("ready2Ps", 32'(bus.ps), 32'd2);
    bus.readyForTransferIn = 1'b1;
    pushTransfer();
    tick();
    chk("xfer2Ps", 32'(bus.ps), 32'd3);
    tick(31);
    chk("abortXferSlow", 32'(bus.slowCount), 32'd7);
    bus.localTransferInput = 2'b10;
    tick();
    bus.localTransferInput = 2'b00;
    sbQ.delete();
    checkIdle("abortXfer");
    tick();
    chk("abortXferNoDone", 32'(bus.commandDoneBit), 32'd0);
    chk("abortXferStay", 32'(bus.ps), 32'd0);

    // Reset during transfer
    bus.readyForTransferIn = 1'b0;
    bus.localTransferInput = 2'b01;
    tick();
    bus.localTransferInput = 2'b00;
    tick(120);
    bus.readyForTransferIn = 1'b1;
    pushTransfer();
    tick();
    tick(70);
    chk("xfer3Ps", 32'(bus.ps), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sbQ.delete();
    checkIdle("rstXfer");
    bus.readyForTransferIn = 1'b0;
    tick(2);
    chk("rstXferStay", 32'(bus.ps), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scanner_ctrl.md
Name: scanner_ctrl

Overview:
Scanner-side controller for a two-device buffered transfer link. On a start command it fills an internal buffer at a divided "slow" rate. Once the buffer is full it waits for the receiver's ready handshake, then drains the buffer as serial 8-bit words with a companion serial clock. It sits between the local command decoder (localTransferInput) and the inter-device serial link (clkOut/dataOut); internal counters are exported for debug.

Parameters:
FULL_LEVEL, 15, buffer level (1..15) at which scanning stops and READY is entered.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
readyForTransferIn  input  1  receiver ready; enables and gates the transfer
localTransferInput  input  2  command: 00 nop, 01 start scan, 10 abort, 11 nop
clkOut  output  1  serial link clock, equal to slowCount[2] in XFER, else 0
dataOut  output  1  serial data, MSB-first; 0 outside XFER
commandDoneBit  output  1  transfer-complete flag
ps  output  2  present state: 00 IDLE, 01 SCAN, 10 READY, 11 XFER
dataBuffer  output  4  buffer fill level (words stored)
slowCount  output  3  clock-divider counter
dataBitCounter  output  3  bit index within the current word (0..7)

Behaviour:
- Reset (rst=1 at a rising edge): ps=00, dataBuffer=0, slowCount=0, dataBitCounter=0, dataOut=0, clkOut=0, commandDoneBit=0. Reset overrides everything, including mid-scan and mid-transfer.
- Slow tick = cycle in which slowCount==7 while slowCount is counting. slowCount increments (mod 8) every clk in SCAN, and in XFER while readyForTransferIn=1. It is held in all other cases and cleared to 0 on every state change.
- IDLE: command 01 -> SCAN on the next cycle, with dataBuffer=0. Other commands are ignored.
- SCAN: on each slow tick dataBuffer increments. The tick that makes dataBuffer==FULL_LEVEL moves to READY. Result: READY is entered exactly 8*FULL_LEVEL clk after entering SCAN (120 for the default).
- READY: counters are held and clkOut=0. readyForTransferIn=1 -> XFER next cycle, with dataBitCounter=0.
- XFER: the current word is {4'b1010, dataBuffer}.
  - dataOut = word[7 - dataBitCounter], registered, stable for a full 8-clk bit period. The receiver samples on the clkOut rising edge (mid-bit).
  - On a slow tick with dataBitCounter<7: dataBitCounter increments.
  - On a slow tick with dataBitCounter==7: dataBitCounter=0 and dataBuffer decrements.
  - If that decrement takes dataBuffer to 0: go to IDLE and pulse commandDoneBit high for exactly one cycle.
  - If readyForTransferIn drops, the transfer pauses: all counters and dataOut are held and clkOut=0. It resumes when readyForTransferIn returns high.
- Abort (command 10) in SCAN, READY or XFER: next cycle IDLE, with dataBuffer, slowCount, dataBitCounter and dataOut all 0. No done pulse.
- Command 01 outside IDLE is ignored.
- Abort takes priority over a simultaneous tick or handshake.
- commandDoneBit is 0 at all other times (see the optional feature for the alternative).

Optional Feature:
SCANNER_DONE_HOLD_EN
- Defined: commandDoneBit is sticky after transfer completion. It stays 1 until the next non-nop command (01 or 10) or reset, and clears in the same cycle that command is accepted.
- Undefined: commandDoneBit is a single-cycle pulse, as described in Behaviour.

Test Plan:
1. Reset: rst=1 for one clk, then 0 with command 00 -> ps=00, all counters 0, dataOut=0, clkOut=0, commandDoneBit=0; state stays IDLE.
2. Scan: command 01 for one cycle then 00 ->
   - ps=01;
   - slowCount counts 0..7 repeatedly;
   - dataBuffer reaches 1 after 8 clk;
   - ps=10 with dataBuffer=15 after 120 clk (default parameter).
3. Handshake: in READY, readyForTransferIn=1 ->
   - ps=11;
   - first word dataOut bits 1,0,1,0,1,1,1,1, each held 8 clk;
   - clkOut has period 8 and rises mid-bit;
   - dataBuffer becomes 14 after 64 clk.
4. Completion: hold readyForTransferIn=1 through the full drain -> after 960 clk of XFER, ps=00, dataBuffer=0, commandDoneBit=1 for exactly one cycle (sticky until the next command when SCANNER_DONE_HOLD_EN is defined).
5. Pause: drop readyForTransferIn for 20 clk mid-word -> counters and dataOut frozen, clkOut=0; the transfer resumes with no lost or duplicated bit.
6. Abort and reset mid-operation: command 10 during SCAN and during XFER -> IDLE with cleared counters and no done pulse. rst=1 during XFER -> full reset values on the next cycle.
